// File: rtl/int_ctrl_pkg.sv
// Shared encodings for the interrupt/exception controller: ids, states, cause sources.
package int_ctrl_pkg;

    localparam logic [3:0]  INT_ID_ERET      = 4'hf;
    localparam logic [15:0] INT_HANDLER_ADDR = 16'h0008;

    localparam logic [1:0] INT_STATE_IDLE    = 2'b00;
    localparam logic [1:0] INT_STATE_ENTER   = 2'b01;
    localparam logic [1:0] INT_STATE_HANDLER = 2'b10;
    localparam logic [1:0] INT_STATE_RETURN  = 2'b11;

    localparam logic CAUSE_SRC_SW = 1'b0;
    localparam logic CAUSE_SRC_HW = 1'b1;

    typedef enum logic [1:0] {
        StIdle    = INT_STATE_IDLE,
        StEnter   = INT_STATE_ENTER,
        StHandler = INT_STATE_HANDLER,
        StReturn  = INT_STATE_RETURN
    } int_state_e;

    // Cause byte layout read by the ID stage: {src, 3'b000, id}.
    function automatic logic [7:0] make_cause(input logic src, input logic [3:0] id);
        return {src, 3'b000, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the external IRQ levels.
module irq_prio_enc #(
    parameter int unsigned LINES = 4
) (
    input  logic [LINES-1:0] irq_i,
    output logic             valid_o,
    output logic [2:0]       index_o
);

    always_comb begin
        valid_o = 1'b0;
        index_o = 3'd0;
        // Scan downwards so the last hit is the lowest set bit.
        for (int i = LINES - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                valid_o = 1'b1;
                index_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Single-level interrupt/exception controller: software INT, ERET and level-sensitive IRQs.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter logic [15:0] HANDLER_ADDR = INT_HANDLER_ADDR,
    parameter int unsigned IRQ_LINES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ici_int,
    input  logic [3:0]           ici_int_id,
    input  logic [15:0]          ici_addr,
    input  logic [IRQ_LINES-1:0] ici_hw_irq,
    input  logic                 ici_pause,
    output logic                 ico_branch,
    output logic [15:0]          ico_new_pc,
    output logic                 ico_flush,
    output logic [7:0]           ico_cause,
    output logic [15:0]          ico_epc,
    output logic                 ico_in_handler
);

    int_state_e  state_q;
    logic [15:0] epc_q;
    logic [7:0]  cause_q;
    logic        branch_q;
    logic        flush_q;
    logic [15:0] new_pc_q;
    logic        in_handler_q;

    logic        irq_valid;
    logic [2:0]  irq_index;
    logic        sw_req;
    logic        eret_req;

    irq_prio_enc #(
        .LINES (IRQ_LINES)
    ) u_prio_enc (
        .irq_i   (ici_hw_irq),
        .valid_o (irq_valid),
        .index_o (irq_index)
    );

    assign sw_req   = !ici_pause && ici_int && (ici_int_id != INT_ID_ERET);
    assign eret_req = !ici_pause && ici_int && (ici_int_id == INT_ID_ERET);

    // Outputs are registered alongside the state so they only depend on flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            epc_q        <= 16'h0000;
            cause_q      <= 8'h00;
            branch_q     <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= 16'h0000;
            in_handler_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sw_req) begin
                        epc_q    <= ici_addr + 16'd1;
                        cause_q  <= make_cause(CAUSE_SRC_SW, ici_int_id);
                        state_q  <= StEnter;
                        branch_q <= 1'b1;
                        flush_q  <= 1'b1;
                        new_pc_q <= HANDLER_ADDR;
                    end else if (!ici_pause && irq_valid) begin
                        // The flushed ID instruction is re-executed after return.
                        epc_q    <= ici_addr;
                        cause_q  <= make_cause(CAUSE_SRC_HW, {1'b0, irq_index});
                        state_q  <= StEnter;
                        branch_q <= 1'b1;
                        flush_q  <= 1'b1;
                        new_pc_q <= HANDLER_ADDR;
                    end
                end
                StEnter: begin
                    if (!ici_pause) begin
                        state_q      <= StHandler;
                        branch_q     <= 1'b0;
                        flush_q      <= 1'b0;
                        new_pc_q     <= 16'h0000;
                        in_handler_q <= 1'b1;
                    end
                end
                StHandler: begin
                    if (eret_req) begin
                        state_q  <= StReturn;
                        branch_q <= 1'b1;
                        flush_q  <= 1'b1;
                        new_pc_q <= epc_q;
                    end
                end
                StReturn: begin
                    if (!ici_pause) begin
                        state_q      <= StIdle;
                        cause_q      <= 8'h00;
                        branch_q     <= 1'b0;
                        flush_q      <= 1'b0;
                        new_pc_q     <= 16'h0000;
                        in_handler_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ico_branch     = branch_q;
    assign ico_flush      = flush_q;
    assign ico_new_pc     = new_pc_q;
    assign ico_cause      = cause_q;
    assign ico_epc        = epc_q;
    assign ico_in_handler = in_handler_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed and randomized bench for int_ctrl against a behavioural handler model.
module tb_int_ctrl;

    localparam logic [15:0] HADDR = 16'h0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ici_int = 1'b0;
    logic [3:0]  ici_int_id = 4'h0;
    logic [15:0] ici_addr = 16'h0000;
    logic [3:0]  ici_hw_irq = 4'h0;
    logic        ici_pause = 1'b0;
    logic        ico_branch;
    logic [15:0] ico_new_pc;
    logic        ico_flush;
    logic [7:0]  ico_cause;
    logic [15:0] ico_epc;
    logic        ico_in_handler;

    int total = 0;
    int bad   = 0;

    // Model: a pending redirect (to handler or back), and whether a handler is live.
    bit          m_redirect;
    bit          m_returning;
    bit          m_busy;
    logic [15:0] m_target;
    logic [15:0] m_epc;
    logic [7:0]  m_cause;

    int_ctrl #(
        .HANDLER_ADDR (HADDR),
        .IRQ_LINES    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ici_int        (ici_int),
        .ici_int_id     (ici_int_id),
        .ici_addr       (ici_addr),
        .ici_hw_irq     (ici_hw_irq),
        .ici_pause      (ici_pause),
        .ico_branch     (ico_branch),
        .ico_new_pc     (ico_new_pc),
        .ico_flush      (ico_flush),
        .ico_cause      (ico_cause),
        .ico_epc        (ico_epc),
        .ico_in_handler (ico_in_handler)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_redirect  = 0;
        m_returning = 0;
        m_busy      = 0;
        m_target    = 16'h0000;
        m_epc       = 16'h0000;
        m_cause     = 8'h00;
    endtask

    task automatic model_step();
        int lowest;
        if (m_redirect) begin
            if (!ici_pause) begin
                m_redirect = 0;
                if (m_returning) begin
                    m_returning = 0;
                    m_busy      = 0;
                    m_cause     = 8'h00;
                end else begin
                    m_busy = 1;
                end
            end
        end else if (m_busy) begin
            if (!ici_pause && ici_int && ici_int_id == 4'hf) begin
                m_redirect  = 1;
                m_returning = 1;
                m_target    = m_epc;
            end
        end else if (!ici_pause) begin
            if (ici_int && ici_int_id != 4'hf) begin
                m_epc      = ici_addr + 16'd1;
                m_cause    = {4'h0, ici_int_id};
                m_redirect = 1;
                m_target   = HADDR;
            end else if (ici_hw_irq != 4'h0) begin
                lowest = 0;
                while (!ici_hw_irq[lowest]) lowest++;
                m_epc      = ici_addr;
                m_cause    = 8'h80 + 8'(lowest);
                m_redirect = 1;
                m_target   = HADDR;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("branch", 32'(ico_branch), 32'(m_redirect));
        check_eq("flush", 32'(ico_flush), 32'(m_redirect));
        if (m_redirect) check_eq("new_pc", 32'(ico_new_pc), 32'(m_target));
        check_eq("cause", 32'(ico_cause), 32'(m_cause));
        check_eq("epc", 32'(ico_epc), 32'(m_epc));
        check_eq("in_handler", 32'(ico_in_handler), 32'(m_busy));
    endtask

    // Called at a falling edge: drive, clock once, then check at the next falling edge.
    task automatic step(input logic i_int, input logic [3:0] id, input logic [15:0] addr,
                        input logic [3:0] irq, input logic p);
        ici_int    = i_int;
        ici_int_id = id;
        ici_addr   = addr;
        ici_hw_irq = irq;
        ici_pause  = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_branch", 32'(ico_branch), 32'h0);
        check_eq("rst_new_pc", 32'(ico_new_pc), 32'h0);
        check_eq("rst_cause", 32'(ico_cause), 32'h0);
        check_eq("rst_epc", 32'(ico_epc), 32'h0);
        check_eq("rst_in_handler", 32'(ico_in_handler), 32'h0);
        rst = 1'b0;

        // SW INT 3, handler, ERET, back to idle
        step(1, 4'h3, 16'h0040, 4'h0, 0);
        check_eq("sw_branch", 32'(ico_branch), 32'h1);
        check_eq("sw_new_pc", 32'(ico_new_pc), 32'h0008);
        check_eq("sw_epc", 32'(ico_epc), 32'h0041);
        check_eq("sw_cause", 32'(ico_cause), 32'h03);
        step(0, 4'h0, 16'h0041, 4'h0, 0);
        check_eq("hdl_in_handler", 32'(ico_in_handler), 32'h1);
        check_eq("hdl_branch", 32'(ico_branch), 32'h0);
        step(1, 4'hf, 16'h0009, 4'h0, 0);
        check_eq("ret_branch", 32'(ico_branch), 32'h1);
        check_eq("ret_new_pc", 32'(ico_new_pc), 32'h0041);
        step(0, 4'h0, 16'h0041, 4'h0, 0);
        check_eq("idle_cause", 32'(ico_cause), 32'h00);
        check_eq("idle_in_handler", 32'(ico_in_handler), 32'h0);

        // HW IRQ, lowest set bit wins
        step(0, 4'h0, 16'h0100, 4'b0110, 0);
        check_eq("hw_cause", 32'(ico_cause), 32'h81);
        check_eq("hw_epc", 32'(ico_epc), 32'h0100);
        check_eq("hw_new_pc", 32'(ico_new_pc), 32'h0008);
        step(0, 4'h0, 16'h0008, 4'h0, 0);
        step(1, 4'hf, 16'h0009, 4'h0, 0);
        step(0, 4'h0, 16'h0100, 4'h0, 0);

        // SW beats HW in the same cycle
        step(1, 4'h5, 16'h0100, 4'b0110, 0);
        check_eq("swhw_cause", 32'(ico_cause), 32'h05);
        check_eq("swhw_epc", 32'(ico_epc), 32'h0101);

        // Pause held in ENTER keeps the redirect
        for (int i = 0; i < 3; i++) begin
            step(0, 4'h0, 16'h0000, 4'h0, 1);
            check_eq("pause_branch", 32'(ico_branch), 32'h1);
            check_eq("pause_new_pc", 32'(ico_new_pc), 32'h0008);
            check_eq("pause_in_handler", 32'(ico_in_handler), 32'h0);
        end
        step(0, 4'h0, 16'h0000, 4'h0, 0);
        check_eq("unpause_in_handler", 32'(ico_in_handler), 32'h1);

        // No nesting in the handler
        step(1, 4'h2, 16'h0200, 4'b1111, 0);
        check_eq("nest_branch", 32'(ico_branch), 32'h0);
        check_eq("nest_cause", 32'(ico_cause), 32'h05);
        check_eq("nest_epc", 32'(ico_epc), 32'h0101);
        step(1, 4'hf, 16'h0009, 4'h0, 0);
        step(0, 4'h0, 16'h0101, 4'h0, 0);

        // Paused INT and ERET in idle are ignored
        step(1, 4'h7, 16'h0300, 4'h0, 1);
        check_eq("paused_int_branch", 32'(ico_branch), 32'h0);
        step(1, 4'hf, 16'h0300, 4'h0, 0);
        check_eq("idle_eret_branch", 32'(ico_branch), 32'h0);
        check_eq("idle_eret_in_handler", 32'(ico_in_handler), 32'h0);

        // Asynchronous reset in the middle of ENTER
        step(0, 4'h0, 16'h0400, 4'b1000, 0);
        check_eq("pre_rst_branch", 32'(ico_branch), 32'h1);
        ici_hw_irq = 4'h0;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_branch", 32'(ico_branch), 32'h0);
        check_eq("async_rst_flush", 32'(ico_flush), 32'h0);
        check_eq("async_rst_epc", 32'(ico_epc), 32'h0);
        check_eq("async_rst_cause", 32'(ico_cause), 32'h0);
        #1 rst = 1'b0;
        model_reset();
        step(0, 4'h0, 16'h0000, 4'h0, 0);
        step(1, 4'h1, 16'hffff, 4'h0, 0);
        check_eq("wrap_epc", 32'(ico_epc), 32'h0000);
        step(0, 4'h0, 16'h0000, 4'h0, 0);
        step(1, 4'hf, 16'h0000, 4'h0, 0);
        step(0, 4'h0, 16'h0000, 4'h0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        r_int;
            logic [3:0]  r_id;
            logic [15:0] r_addr;
            logic [3:0]  r_irq;
            logic        r_pause;
            r_int   = ($urandom_range(0, 3) == 0);
            r_id    = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
            r_addr  = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom);
            r_irq   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            r_pause = ($urandom_range(0, 3) == 0);
            step(r_int, r_id, r_addr, r_irq, r_pause);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
